// File: rtl/mux_pkg.sv
// Shared mode encodings and width helper for the round-robin N:1 stream mux.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_nx1_rr_arbiter.sv
// Channel arbiter: round-robin or fixed-select grant, with the rotating pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             advance,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] rr_ptr;

  // Scan starts just past the last round-robin winner and wraps.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (mode == MODE_FIXED) begin
      if ((32'(sel) < N_CH) && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= N_CH; k++) begin
        idx = (32'(rr_ptr) + k) % N_CH;
        if (!found && req[SEL_W'(idx)]) begin
          found                = 1'b1;
          grant[SEL_W'(idx)]   = 1'b1;
          grant_idx            = SEL_W'(idx);
        end
      end
    end
  end

  // Pointer only tracks round-robin winners; fixed mode leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SEL_W'(N_CH - 1);
    end else if (advance && (mode == MODE_RR)) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-channel to 1 streaming mux with a one-entry registered output stage.
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic              load;
  logic              xfer;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;

  // Buffer can take a word when empty or being drained this cycle.
  assign load     = !out_valid | out_ready;
  assign xfer     = load & (|grant);
  assign in_ready = grant & {N_CH{load}};

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .mode      (mode),
    .sel       (sel),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot AND-OR select of the granted word.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Data/channel hold their last value when the buffer empties without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= grant_data;
        out_ch   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed and randomized bench for mux_rr_nx1 against a behavioural model.
module tb_mux_rr_nx1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_ch;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the held word and the last round-robin winner.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;
  logic         x_valid;
  logic [W-1:0] x_data;
  int           x_ch;
  int           x_ptr;

  mux_rr_nx1 #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel that must win given the current requests, or -1.
  function automatic int pick(input logic m, input int s, input logic [N-1:0] v, input int p);
    if (m) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      int g;
      logic ld;
      logic [N-1:0] exp_rdy;
      g  = pick(mode, int'(sel), in_valid, m_ptr);
      ld = !m_valid || out_ready;
      exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      x_valid = m_valid; x_data = m_data; x_ch = m_ch; x_ptr = m_ptr;
      if (ld) begin
        x_valid = (g >= 0);
        if (g >= 0) begin
          x_data = in_data[g*W +: W];
          x_ch   = g;
          if (!mode) x_ptr = g;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_data <= '0; m_ch <= 0; m_ptr <= N - 1;
    end else begin
      m_valid <= x_valid; m_data <= x_data; m_ch <= x_ch; m_ptr <= x_ptr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] mf_exp [4];
    mf_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    step();

    // Fixed select stepping through every channel.
    mode = 1'b1; in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = SW'(s);
      step();
      #1;
      chk("fixed_data", 32'(out_data), 32'(mf_exp[s]));
      chk("fixed_ch", 32'(out_ch), 32'(s));
    end

    // Round-robin with every channel requesting.
    mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_one_ready", 32'($countones(in_ready)), 32'd1);
      step();
      chk("rr_seq_ch", 32'(out_ch), 32'(k % 4));
    end

    // Sparse requesters 1 and 3.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sparse_no_ready_0_2", 32'(in_ready & 4'b0101), 32'd0);
      step();
      chk("sparse_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure with a ch2 word held.
    in_valid = 4'b0100;
    step();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'hCC);
      chk("stall_ch", 32'(out_ch), 32'd2);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 32'b1000);
    step();
    chk("release_ch", 32'(out_ch), 32'd3);

    // Fixed select on an idle channel, then it becomes valid.
    mode = 1'b1; sel = 2'd2; in_valid = 4'b1011;
    #1;
    chk("idle_sel_ready", 32'(in_ready), 32'd0);
    step();
    chk("idle_sel_pop", 32'(out_valid), 32'd0);
    in_valid = 4'b1111;
    step();
    chk("sel2_valid", 32'(out_valid), 32'd1);
    chk("sel2_data", 32'(out_data), 32'hCC);
    chk("sel2_ch", 32'(out_ch), 32'd2);

    // Asynchronous reset while stalled.
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      mode      = ($urandom_range(0, 3) == 0);
      sel       = SW'($urandom_range(0, N - 1));
      in_data   = $urandom;
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
